target_pos_gen: RTL and testbench

//  Parametrised random target (frog) position generator for the game core. Two free-running

---
 rtl/target_pos_gen_if.sv | 25 ++
 rtl/target_pos_gen.sv | 163 ++++++++++++++++
 tb/tb_target_pos_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/target_pos_gen_if.sv
// rtl/target_pos_gen_if.sv - request/target bundle between game-state logic and target_pos_gen
interface target_pos_gen_if #(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 7
);
  logic                     target_ate;
  logic [X_BITS-1:0]        avoid_x;
  logic [Y_BITS-1:0]        avoid_y;
  logic [X_BITS-1:0]        target_x;
  logic [Y_BITS-1:0]        target_y;
  logic [X_BITS+Y_BITS-1:0] rnd_addr;
  logic                     valid;
  logic                     busy;
  logic                     fallback;

  modport master (
    output target_ate, avoid_x, avoid_y,
    input  target_x, target_y, rnd_addr, valid, busy, fallback
  );

  modport slave (
    input  target_ate, avoid_x, avoid_y,
    output target_x, target_y, rnd_addr, valid, busy, fallback
  );
endinterface

// File: rtl/target_pos_gen.sv
// rtl/target_pos_gen.sv - LFSR-driven target position generator with range/avoid retry and fallback
module target_pos_gen #(
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int X_MAX     = 159,
  parameter int Y_MAX     = 119,
  parameter int SEED_X    = 1,
  parameter int SEED_Y    = 1,
  parameter int MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  target_pos_gen_if.slave  bus
);

  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      2:       tap_mask = 16'h0003;
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0003;
    endcase
  endfunction

  generate
    if (X_BITS < 2 || X_BITS > 16 || Y_BITS < 2 || Y_BITS > 16) begin : g_bad_width
      $error("target_pos_gen: X_BITS/Y_BITS must be 2..16");
    end
    if ((SEED_X % (1 << X_BITS)) == 0 || (SEED_Y % (1 << Y_BITS)) == 0) begin : g_bad_seed
      $error("target_pos_gen: LFSR seeds must be non-zero");
    end
    if (X_MAX < 0 || Y_MAX < 0 || X_MAX >= (1 << X_BITS) || Y_MAX >= (1 << Y_BITS)) begin : g_bad_max
      $error("target_pos_gen: X_MAX/Y_MAX out of coordinate range");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
      $error("target_pos_gen: MAX_TRIES must be 1..255");
    end
  endgenerate

  localparam logic [X_BITS-1:0] X_MASK   = X_BITS'(tap_mask(X_BITS));
  localparam logic [Y_BITS-1:0] Y_MASK   = Y_BITS'(tap_mask(Y_BITS));
  localparam logic [X_BITS-1:0] X_SEED   = X_BITS'(SEED_X);
  localparam logic [Y_BITS-1:0] Y_SEED   = Y_BITS'(SEED_Y);
  localparam logic [X_BITS-1:0] X_LIM    = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0] Y_LIM    = Y_BITS'(Y_MAX);
  localparam logic [7:0]        LAST_TRY = 8'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, DRAW, CHECK, DONE} state_t;

  state_t            state, state_nx;
  logic [X_BITS-1:0] lfsr_x, cand_x, cand_x_nx, tgt_x, tgt_x_nx;
  logic [Y_BITS-1:0] lfsr_y, cand_y, cand_y_nx, tgt_y, tgt_y_nx;
  logic [7:0]        tries, tries_nx;
  logic              pending, pending_nx;
  logic              fb, fb_nx;
  logic              accept;

  // Free-running; the all-zero lock-up state can only be reached by a glitch, so just reseed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_x <= X_SEED;
      lfsr_y <= Y_SEED;
    end else begin
      lfsr_x <= (lfsr_x == '0) ? X_SEED : {lfsr_x[X_BITS-2:0], ^(lfsr_x & X_MASK)};
      lfsr_y <= (lfsr_y == '0) ? Y_SEED : {lfsr_y[Y_BITS-2:0], ^(lfsr_y & Y_MASK)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tries   <= '0;
      pending <= 1'b0;
      cand_x  <= '0;
      cand_y  <= '0;
      tgt_x   <= '0;
      tgt_y   <= '0;
      fb      <= 1'b0;
    end else begin
      state   <= state_nx;
      tries   <= tries_nx;
      pending <= pending_nx;
      cand_x  <= cand_x_nx;
      cand_y  <= cand_y_nx;
      tgt_x   <= tgt_x_nx;
      tgt_y   <= tgt_y_nx;
      fb      <= fb_nx;
    end
  end

  assign accept = (cand_x <= X_LIM) && (cand_y <= Y_LIM) &&
                  !((cand_x == bus.avoid_x) && (cand_y == bus.avoid_y));

  always_comb begin
    state_nx   = state;
    tries_nx   = tries;
    pending_nx = pending;
    cand_x_nx  = cand_x;
    cand_y_nx  = cand_y;
    tgt_x_nx   = tgt_x;
    tgt_y_nx   = tgt_y;
    fb_nx      = fb;
    // Requests arriving mid-operation collapse into a single queued request.
    if (state != IDLE && bus.target_ate) pending_nx = 1'b1;
    case (state)
      IDLE: begin
        if (bus.target_ate || pending) begin
          state_nx   = DRAW;
          tries_nx   = '0;
          pending_nx = 1'b0;
        end
      end
      DRAW: begin
        cand_x_nx = lfsr_x;
        cand_y_nx = lfsr_y;
        state_nx  = CHECK;
      end
      CHECK: begin
        if (accept) begin
          tgt_x_nx = cand_x;
          tgt_y_nx = cand_y;
          fb_nx    = 1'b0;
          state_nx = DONE;
        end else if (tries == LAST_TRY) begin
          if (bus.avoid_x == '0 && bus.avoid_y == '0) begin
            tgt_x_nx = X_LIM;
            tgt_y_nx = Y_LIM;
          end else begin
            tgt_x_nx = '0;
            tgt_y_nx = '0;
          end
          fb_nx    = 1'b1;
          state_nx = DONE;
        end else begin
          tries_nx = tries + 8'd1;
          state_nx = DRAW;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.target_x = tgt_x;
  assign bus.target_y = tgt_y;
  assign bus.rnd_addr = {tgt_x, tgt_y};
  assign bus.fallback = fb;
  assign bus.valid    = (state == DONE);
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_target_pos_gen.sv
// tb/tb_target_pos_gen.sv - directed self-checking bench for target_pos_gen
module tb_target_pos_gen;

  localparam int DX_MAX = 159;
  localparam int DY_MAX = 119;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  target_pos_gen_if #(.X_BITS(8), .Y_BITS(7)) if_d ();
  target_pos_gen_if #(.X_BITS(8), .Y_BITS(7)) if_f ();
  target_pos_gen_if #(.X_BITS(8), .Y_BITS(7)) if_b ();
  target_pos_gen_if #(.X_BITS(8), .Y_BITS(7)) if_c ();

  target_pos_gen u_dut (.clk(clk), .rst_n(rst_n), .bus(if_d));
  target_pos_gen #(.X_MAX(255), .Y_MAX(127)) u_full (.clk(clk), .rst_n(rst_n), .bus(if_f));
  target_pos_gen #(.X_MAX(0), .Y_MAX(0), .MAX_TRIES(4)) u_fb (.clk(clk), .rst_n(rst_n), .bus(if_b));
  target_pos_gen #(.X_MAX(0), .Y_MAX(5), .MAX_TRIES(2)) u_fb2 (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // Reference LFSRs: x^8+x^6+x^5+x^4+1 and x^7+x^6+1, shifted toward the MSB.
  function automatic logic [7:0] nx8(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  function automatic logic [6:0] nx7(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  logic [7:0] mx;
  logic [6:0] my;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx <= 8'd1;
      my <= 7'd1;
    end else begin
      mx <= nx8(mx);
      my <= nx7(my);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge inside the DRAW period of the default instance.
  task automatic await_d(input logic [7:0] ax, input logic [6:0] ay, output int rej);
    logic [7:0] sx;
    logic [6:0] sy;
    bit         fbk;
    bit         bad;
    int         k;
    sx = mx; sy = my; fbk = 1'b0;
    for (k = 0; k < 16; k++) begin
      if (sx <= DX_MAX && sy <= DY_MAX && !(sx == ax && sy == ay)) break;
      if (k == 15) begin
        fbk = 1'b1;
        break;
      end
      sx = nx8(nx8(sx));
      sy = nx7(nx7(sy));
    end
    if (fbk) begin
      sx = (ax == 0 && ay == 0) ? 8'(DX_MAX) : 8'd0;
      sy = (ax == 0 && ay == 0) ? 7'(DY_MAX) : 7'd0;
    end
    bad = 1'b0;
    repeat (2 * k + 1) begin
      @(negedge clk);
      if (if_d.valid !== 1'b0) bad = 1'b1;
    end
    chk("d_early_valid", bad, 0);
    @(negedge clk);
    chk("d_valid", if_d.valid, 1);
    chk("d_tx", if_d.target_x, sx);
    chk("d_ty", if_d.target_y, sy);
    chk("d_fb", if_d.fallback, fbk);
    chk("d_in_range", (if_d.target_x <= DX_MAX) && (if_d.target_y <= DY_MAX), 1);
    if (!fbk) chk("d_not_avoid", (if_d.target_x == ax) && (if_d.target_y == ay), 0);
    rej = k;
  endtask

  task automatic req_d(input logic [7:0] ax, input logic [6:0] ay, input bit hit, output int rej);
    @(negedge clk);
    if_d.avoid_x = ax; if_d.avoid_y = ay; if_d.target_ate = 1'b1;
    @(negedge clk);
    if_d.target_ate = 1'b0;
    if (hit) begin
      ax = mx; ay = my;
      if_d.avoid_x = ax; if_d.avoid_y = ay;
    end
    await_d(ax, ay, rej);
  endtask

  initial begin
    logic [7:0] ex;
    logic [6:0] ey;
    bit         bad;
    int         rej;

    if_d.target_ate = 1'b1; if_d.avoid_x = '0; if_d.avoid_y = '0;
    if_f.target_ate = 1'b1; if_f.avoid_x = '0; if_f.avoid_y = '0;
    if_b.target_ate = 1'b1; if_b.avoid_x = '0; if_b.avoid_y = '0;
    if_c.target_ate = 1'b1; if_c.avoid_x = '0; if_c.avoid_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", if_d.valid, 0);
    chk("rst_busy", if_d.busy, 0);
    chk("rst_addr", if_d.rnd_addr, 0);
    chk("rst_fb", if_d.fallback, 0);
    chk("rst_busy_f", if_f.busy, 0);
    if_d.target_ate = 1'b0; if_f.target_ate = 1'b0;
    if_b.target_ate = 1'b0; if_c.target_ate = 1'b0;
    rst_n = 1'b1;

    // Full-range instance: every draw is legal, so the target is the DRAW-cycle LFSR pair.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      if_f.target_ate = 1'b1;
      @(negedge clk);
      if_f.target_ate = 1'b0;
      ex = mx; ey = my;
      chk("f_busy1", if_f.busy, 1);
      chk("f_valid1", if_f.valid, 0);
      @(negedge clk);
      chk("f_busy2", if_f.busy, 1);
      chk("f_valid2", if_f.valid, 0);
      @(negedge clk);
      chk("f_valid3", if_f.valid, 1);
      chk("f_busy3", if_f.busy, 1);
      chk("f_addr", if_f.rnd_addr, {ex, ey});
      chk("f_fb", if_f.fallback, 0);
      @(negedge clk);
      chk("f_valid4", if_f.valid, 0);
      chk("f_busy4", if_f.busy, 0);
      chk("f_hold", if_f.rnd_addr, {ex, ey});
    end

    for (int r = 0; r < 1000; r++)
      req_d(8'($urandom_range(0, DX_MAX)), 7'($urandom_range(0, DY_MAX)), 1'b0, rej);

    // Avoid cell set to the upcoming candidate: first draw must be thrown away.
    for (int r = 0; r < 4; r++) begin
      req_d(8'd0, 7'd0, 1'b1, rej);
      chk("hit_not_avoid", {if_d.target_x, if_d.target_y} == {if_d.avoid_x, if_d.avoid_y}, 0);
    end

    // X_MAX=0 can never be met by a non-zero X LFSR, so MAX_TRIES=4 always falls back at +9.
    @(negedge clk);
    if_b.target_ate = 1'b1;
    @(negedge clk);
    if_b.target_ate = 1'b0;
    chk("b_busy", if_b.busy, 1);
    bad = 1'b0;
    repeat (7) begin
      @(negedge clk);
      if (if_b.valid !== 1'b0) bad = 1'b1;
    end
    chk("b_early_valid", bad, 0);
    @(negedge clk);
    chk("b_valid", if_b.valid, 1);
    chk("b_fb", if_b.fallback, 1);
    chk("b_addr", if_b.rnd_addr, 0);

    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      if_c.avoid_x = 8'(r); if_c.avoid_y = 7'(r); if_c.target_ate = 1'b1;
      @(negedge clk);
      if_c.target_ate = 1'b0;
      bad = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (if_c.valid !== 1'b0) bad = 1'b1;
      end
      chk("c_early_valid", bad, 0);
      @(negedge clk);
      chk("c_valid", if_c.valid, 1);
      chk("c_fb", if_c.fallback, 1);
      chk("c_tx", if_c.target_x, 0);
      chk("c_ty", if_c.target_y, (r == 0) ? 5 : 0);
    end

    // Second request raised during DRAW queues and runs right after the first.
    @(negedge clk);
    if_d.avoid_x = 8'd200; if_d.avoid_y = 7'd0; if_d.target_ate = 1'b1;
    @(negedge clk);
    fork
      begin
        @(negedge clk);
        if_d.target_ate = 1'b0;
      end
    join_none
    await_d(8'd200, 7'd0, rej);
    @(negedge clk);
    chk("pend_idle_busy", if_d.busy, 0);
    chk("pend_idle_valid", if_d.valid, 0);
    @(negedge clk);
    chk("pend_draw_busy", if_d.busy, 1);
    await_d(8'd200, 7'd0, rej);

    // Reset in CHECK with a request pending: everything clears, nothing follows.
    @(negedge clk);
    if_d.target_ate = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if_d.target_ate = 1'b0;
    chk("rc_busy", if_d.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rc_valid", if_d.valid, 0);
    chk("rc_busy0", if_d.busy, 0);
    chk("rc_addr", if_d.rnd_addr, 0);
    chk("rc_fb", if_d.fallback, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (if_d.valid !== 1'b0 || if_d.busy !== 1'b0) bad = 1'b1;
    end
    chk("rc_no_activity", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
